// File: rtl/pipeline_sequencer_pkg.sv
// Shared types and codes for the pipeline hazard/sequencing controller.
package pipeline_sequencer_pkg;

    localparam int unsigned REG_W = 4;
    localparam int unsigned FWD_W = 2;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } seq_state_e;

    localparam logic [FWD_W-1:0] FWD_RF    = 2'd0;
    localparam logic [FWD_W-1:0] FWD_EXMEM = 2'd1;
    localparam logic [FWD_W-1:0] FWD_MEMWB = 2'd2;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
        logic             load;
    } ex_slot_t;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
    } slot_t;

    function automatic logic src_hit(input logic en, input logic v,
                                     input logic [REG_W-1:0] a,
                                     input logic [REG_W-1:0] b);
        return en & v & (a == b);
    endfunction

    // Youngest non-load producer wins; a load is only reachable from MEM.
    function automatic logic [FWD_W-1:0] fwd_sel(input logic en,
                                                 input logic [REG_W-1:0] src,
                                                 input ex_slot_t ex,
                                                 input slot_t mem);
        if (src_hit(en, ex.v, src, ex.rd) && !ex.load) return FWD_EXMEM;
        if (src_hit(en, mem.v, src, mem.rd))           return FWD_MEMWB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipeline_sequencer_hazard_scoreboard.sv
// Destination-register scoreboard for EX/MEM/WB with load-use and forward-select decode.
module hazard_scoreboard
    import pipeline_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_i,
    input  logic             wr_en_i,
    input  logic [REG_W-1:0] wr_i,
    input  logic             load_i,
    input  logic [REG_W-1:0] rd0_i,
    input  logic             rd0_en_i,
    input  logic [REG_W-1:0] rd1_i,
    input  logic             rd1_en_i,
    output logic             load_use_c,
    output logic [FWD_W-1:0] fwd0_nxt_c,
    output logic [FWD_W-1:0] fwd1_nxt_c,
    output logic             busy_c
);

    ex_slot_t ex_q, ex_d;
    slot_t    mem_q, wb_q;

    always_comb begin
        ex_d = '0;
        if (issue_i) ex_d = '{v: wr_en_i, rd: wr_i, load: load_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= '{v: ex_q.v, rd: ex_q.rd};
            wb_q  <= mem_q;
        end
    end

    assign load_use_c = ex_q.load & (src_hit(rd0_en_i, ex_q.v, rd0_i, ex_q.rd) |
                                     src_hit(rd1_en_i, ex_q.v, rd1_i, ex_q.rd));
    assign fwd0_nxt_c = fwd_sel(rd0_en_i, rd0_i, ex_q, mem_q);
    assign fwd1_nxt_c = fwd_sel(rd1_en_i, rd1_i, ex_q, mem_q);
    assign busy_c     = ex_q.v | mem_q.v | wb_q.v;

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline hazard controller: load-use stall, branch flush, forwarding selects and halt/drain FSM.
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int unsigned NREG      = 8,
    parameter int unsigned DRAIN_CYC = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rd0,
    input  logic [REG_W-1:0] id_rd1,
    input  logic             id_rd0_en,
    input  logic             id_rd1_en,
    input  logic             id_write,
    input  logic [REG_W-1:0] id_wr,
    input  logic             id_load,
    input  logic             id_halt,
    input  logic             ex_branch_taken,
    input  logic             restart,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [FWD_W-1:0] fwd0,
    output logic [FWD_W-1:0] fwd1,
    output logic             halted
);

    localparam int unsigned CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    if (NREG == 0 || NREG > (1 << REG_W)) begin : g_nreg_chk
        $error("NREG does not fit the 4-bit register ID space");
    end

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [FWD_W-1:0] fwd0_q, fwd0_d, fwd1_q, fwd1_d;
    logic             halted_q;
    logic             load_use, sb_busy;
    logic [FWD_W-1:0] fwd0_nxt, fwd1_nxt;
    logic             run, br_flush, stall, halt_det, issue;

    hazard_scoreboard u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_i    (issue),
        .wr_en_i    (id_write),
        .wr_i       (id_wr),
        .load_i     (id_load),
        .rd0_i      (id_rd0),
        .rd0_en_i   (id_rd0_en),
        .rd1_i      (id_rd1),
        .rd1_en_i   (id_rd1_en),
        .load_use_c (load_use),
        .fwd0_nxt_c (fwd0_nxt),
        .fwd1_nxt_c (fwd1_nxt),
        .busy_c     (sb_busy)
    );

    // A taken branch in EX dominates both the stall and halt detection.
    assign run      = (state_q == ST_RUN);
    assign br_flush = run & ex_branch_taken;
    assign stall    = run & id_valid & load_use & ~ex_branch_taken;
    assign halt_det = run & id_valid & id_halt & ~ex_branch_taken;
    assign issue    = run & id_valid & ~load_use & ~ex_branch_taken & ~id_halt;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (br_flush) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (stall) begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_bubble = 1'b1;
                end
                if (halt_det) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_W'(DRAIN_CYC - 1);
                end
            end
            ST_DRAIN: begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_bubble = 1'b1;
                if (cnt_q == '0) state_d = ST_HALTED;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_HALTED: begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_bubble = 1'b1;
                if (restart) begin
                    if_id_flush = 1'b1;
                    state_d     = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
        fwd0_d = issue ? fwd0_nxt : FWD_RF;
        fwd1_d = issue ? fwd1_nxt : FWD_RF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            fwd0_q   <= FWD_RF;
            fwd1_q   <= FWD_RF;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fwd0_q   <= fwd0_d;
            fwd1_q   <= fwd1_d;
            halted_q <= (state_d == ST_HALTED);
        end
    end

    assign fwd0   = fwd0_q;
    assign fwd1   = fwd1_q;
    assign halted = halted_q;

    // Once parked, every in-flight writer has retired.
    a_parked_empty: assert property (@(posedge clk) disable iff (!rst_n)
        (DRAIN_CYC >= 3 && state_q == ST_HALTED) |-> !sb_busy);

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: forwarding, load-use, branch flush, halt/restart, reset.
module tb_pipeline_sequencer;
    import pipeline_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_rd0_en, id_rd1_en, id_write, id_load, id_halt;
    logic [3:0] id_rd0, id_rd1, id_wr;
    logic       ex_branch_taken, restart;
    logic       pc_en, if_id_en, if_id_flush, id_ex_bubble, halted;
    logic [1:0] fwd0, fwd1;
    int         n_chk = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    pipeline_sequencer #(.NREG(8), .DRAIN_CYC(3)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rd0(id_rd0), .id_rd1(id_rd1), .id_rd0_en(id_rd0_en), .id_rd1_en(id_rd1_en),
        .id_write(id_write), .id_wr(id_wr), .id_load(id_load), .id_halt(id_halt),
        .ex_branch_taken(ex_branch_taken), .restart(restart),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .fwd0(fwd0), .fwd1(fwd1), .halted(halted)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        id_valid = 0; id_rd0 = 0; id_rd1 = 0; id_rd0_en = 0; id_rd1_en = 0;
        id_write = 0; id_wr = 0; id_load = 0; id_halt = 0;
        ex_branch_taken = 0; restart = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #3;
        chk("rst_pc_en", 8'(pc_en), 8'd1);
        chk("rst_if_id_en", 8'(if_id_en), 8'd1);
        chk("rst_flush", 8'(if_id_flush), 8'd0);
        chk("rst_bubble", 8'(id_ex_bubble), 8'd0);
        chk("rst_fwd0", 8'(fwd0), 8'd0);
        chk("rst_fwd1", 8'(fwd1), 8'd0);
        chk("rst_halted", 8'(halted), 8'd0);
        settle(); rst_n = 1'b1;
        tick();

        // ALU producer r9, consumer reads r9 on rd0 and r1 on rd1 (4-bit compare)
        id_valid = 1; id_write = 1; id_wr = 4'd9;
        tick();
        idle(); id_valid = 1; id_rd0 = 4'd9; id_rd0_en = 1; id_rd1 = 4'd1; id_rd1_en = 1;
        settle();
        chk("alu_no_stall_pc", 8'(pc_en), 8'd1);
        chk("alu_no_bubble", 8'(id_ex_bubble), 8'd0);
        tick();
        chk("alu_fwd0_exmem", 8'(fwd0), 8'd1);
        chk("alu_fwd1_rf", 8'(fwd1), 8'd0);

        // Producer r3, unrelated op, consumer on rd1 -> MEM/WB; rd0 same ID but disabled
        idle(); id_valid = 1; id_write = 1; id_wr = 4'd3;
        tick();
        idle(); id_valid = 1;
        tick();
        idle(); id_valid = 1; id_rd1 = 4'd3; id_rd1_en = 1; id_rd0 = 4'd3; id_rd0_en = 0;
        tick();
        chk("mem_fwd1", 8'(fwd1), 8'd2);
        chk("mem_fwd0_disabled", 8'(fwd0), 8'd0);
        idle();
        tick();
        chk("fwd1_cleared_idle", 8'(fwd1), 8'd0);

        // Load r2 then use on rd1: one stall cycle, then MEM/WB forward
        idle(); id_valid = 1; id_write = 1; id_wr = 4'd2; id_load = 1;
        tick();
        idle(); id_valid = 1; id_rd1 = 4'd2; id_rd1_en = 1;
        settle();
        chk("lu_pc_en", 8'(pc_en), 8'd0);
        chk("lu_if_id_en", 8'(if_id_en), 8'd0);
        chk("lu_bubble", 8'(id_ex_bubble), 8'd1);
        tick();
        chk("lu_fwd1_bubble", 8'(fwd1), 8'd0);
        settle();
        chk("lu_second_pc_en", 8'(pc_en), 8'd1);
        chk("lu_second_bubble", 8'(id_ex_bubble), 8'd0);
        tick();
        chk("lu_fwd1_memwb", 8'(fwd1), 8'd2);

        // Branch taken while a load-use stall is pending
        idle(); id_valid = 1; id_write = 1; id_wr = 4'd4; id_load = 1;
        tick();
        idle(); id_valid = 1; id_rd0 = 4'd4; id_rd0_en = 1; ex_branch_taken = 1;
        settle();
        chk("br_flush", 8'(if_id_flush), 8'd1);
        chk("br_pc_en", 8'(pc_en), 8'd1);
        chk("br_bubble", 8'(id_ex_bubble), 8'd1);
        tick();
        chk("br_fwd0", 8'(fwd0), 8'd0);

        // Halt, drain 3 cycles, park, restart
        idle(); id_valid = 1; id_write = 1; id_wr = 4'd5;
        tick();
        idle(); id_valid = 1; id_halt = 1;
        settle();
        chk("halt_det_flush", 8'(if_id_flush), 8'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            ex_branch_taken = (i == 1);
            restart = (i == 2);
            settle();
            chk("drain_pc_en", 8'(pc_en), 8'd0);
            chk("drain_bubble", 8'(id_ex_bubble), 8'd1);
            chk("drain_flush", 8'(if_id_flush), 8'd0);
            chk("drain_halted", 8'(halted), 8'd0);
            tick();
        end
        ex_branch_taken = 0; restart = 0;
        settle();
        chk("halted_set", 8'(halted), 8'd1);
        chk("halted_pc_en", 8'(pc_en), 8'd0);
        chk("halted_if_id_en", 8'(if_id_en), 8'd0);
        tick(); tick();
        restart = 1;
        settle();
        chk("restart_flush", 8'(if_id_flush), 8'd1);
        chk("restart_pc_en", 8'(pc_en), 8'd0);
        tick();
        idle(); id_valid = 1; id_rd0 = 4'd5; id_rd0_en = 1;
        settle();
        chk("run_pc_en", 8'(pc_en), 8'd1);
        chk("run_flush", 8'(if_id_flush), 8'd0);
        chk("run_halted", 8'(halted), 8'd0);
        tick();
        chk("sb_drained_fwd0", 8'(fwd0), 8'd0);

        // Restart in RUN has no effect
        idle(); restart = 1;
        settle();
        chk("restart_in_run", 8'(if_id_flush), 8'd0);
        tick();

        // Halt together with a taken branch is squashed
        idle(); id_valid = 1; id_halt = 1; ex_branch_taken = 1;
        settle();
        chk("hb_flush", 8'(if_id_flush), 8'd1);
        tick();
        idle();
        settle();
        chk("hb_pc_en", 8'(pc_en), 8'd1);
        chk("hb_bubble", 8'(id_ex_bubble), 8'd0);
        repeat (4) tick();
        chk("hb_halted", 8'(halted), 8'd0);

        // Reset during DRAIN; MEM slot would otherwise hold r6
        idle(); id_valid = 1; id_write = 1; id_wr = 4'd6;
        tick();
        idle(); id_valid = 1; id_halt = 1;
        tick();
        settle();
        chk("pre_rst_drain_pc", 8'(pc_en), 8'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_drain_pc_en", 8'(pc_en), 8'd1);
        chk("rst_drain_bubble", 8'(id_ex_bubble), 8'd0);
        chk("rst_drain_halted", 8'(halted), 8'd0);
        chk("rst_drain_fwd0", 8'(fwd0), 8'd0);
        idle(); id_valid = 1; id_rd0 = 4'd6; id_rd0_en = 1;
        #1 rst_n = 1'b1;
        tick();
        chk("rst_sb_cleared", 8'(fwd0), 8'd0);

        // Reset while HALTED drops halted immediately
        idle(); id_valid = 1; id_halt = 1;
        tick();
        idle();
        repeat (4) tick();
        chk("pre_rst_halted", 8'(halted), 8'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_halted_clear", 8'(halted), 8'd0);
        chk("rst_halted_pc_en", 8'(pc_en), 8'd1);
        settle(); rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
